// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO of DEPTH words of DATA_WIDTH bits.
// DEPTH may be any integer >= 2 because the pointers wrap by explicit compare.
// Provides an occupancy count, registered status flags and overflow/underflow pulses.
// FWFT selects a registered read (0) or first-word-fall-through (1) output.
module fifo_sync_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1,
    parameter bit FWFT          = 1'b0,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  R_INC,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [CW-1:0]         COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [CW-1:0]         count, count_nxt;
    logic                  full_q, empty_q, afull_q, aempty_q, ovf_q, udf_q;
    logic                  wr_acc, rd_acc;

    // Pointer increment with wrap at DEPTH-1, so non-power-of-two depths stay in range.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Acceptance uses the registered flags: a full FIFO rejects the write even if
    // a read is accepted in the same cycle, and an empty one rejects the read.
    assign wr_acc    = W_INC & ~full_q;
    assign rd_acc    = R_INC & ~empty_q;
    assign count_nxt = count + CW'(wr_acc) - CW'(rd_acc);

    // Pointers, occupancy and flags; flags come from next count so they track COUNT exactly.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_acc) wptr <= ptr_inc(wptr);
            if (rd_acc) rptr <= ptr_inc(rptr);
            count    <= count_nxt;
            full_q   <= (count_nxt == CW'(DEPTH));
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= CW'(AFULL_THRESH));
            aempty_q <= (count_nxt <= CW'(AEMPTY_THRESH));
            ovf_q    <= W_INC & full_q;
            udf_q    <= R_INC & empty_q;
        end
    end

    // Storage is not reset; a write coinciding with reset is dropped.
    always_ff @(posedge CLK) begin
        if (wr_acc && !RST) mem[wptr] <= WR_DATA;
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is always presented; R_INC consumes it.
            assign RD_DATA  = mem[rptr];
            assign RD_VALID = ~empty_q;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // Registered read: data appears one cycle after an accepted pop and then holds.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem[rptr];
                end
            end

            assign RD_DATA  = rd_data_q;
            assign RD_VALID = rd_valid_q;
        end
    endgenerate

    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = afull_q;
    assign ALMOST_EMPTY = aempty_q;
    assign COUNT        = count;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a vector table on an 8-deep standard-read FIFO,
// a wrap sequence on a 5-deep FIFO and a fall-through sequence on an 8-deep FWFT FIFO.
// Read data is checked against a queue filled as writes are driven.
module tb_fifo_sync_param;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // instance A: DEPTH 8, standard read
    logic       a_rst, a_w, a_r, a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [7:0] a_wd, a_rd;
    logic [3:0] a_cnt;
    // instance B: DEPTH 5, standard read
    logic       b_rst, b_w, b_r, b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [7:0] b_wd, b_rd;
    logic [2:0] b_cnt;
    // instance C: DEPTH 8, first-word-fall-through
    logic       c_rst, c_w, c_r, c_rv, c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
    logic [7:0] c_wd, c_rd;
    logic [3:0] c_cnt;

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(1), .FWFT(1'b0)) u_a (
        .CLK(CLK), .RST(a_rst), .W_INC(a_w), .WR_DATA(a_wd), .R_INC(a_r),
        .RD_DATA(a_rd), .RD_VALID(a_rv), .FULL(a_full), .EMPTY(a_empty),
        .ALMOST_FULL(a_af), .ALMOST_EMPTY(a_ae), .COUNT(a_cnt),
        .OVERFLOW(a_ovf), .UNDERFLOW(a_udf));

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1), .FWFT(1'b0)) u_b (
        .CLK(CLK), .RST(b_rst), .W_INC(b_w), .WR_DATA(b_wd), .R_INC(b_r),
        .RD_DATA(b_rd), .RD_VALID(b_rv), .FULL(b_full), .EMPTY(b_empty),
        .ALMOST_FULL(b_af), .ALMOST_EMPTY(b_ae), .COUNT(b_cnt),
        .OVERFLOW(b_ovf), .UNDERFLOW(b_udf));

    fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(1), .FWFT(1'b1)) u_c (
        .CLK(CLK), .RST(c_rst), .W_INC(c_w), .WR_DATA(c_wd), .R_INC(c_r),
        .RD_DATA(c_rd), .RD_VALID(c_rv), .FULL(c_full), .EMPTY(c_empty),
        .ALMOST_FULL(c_af), .ALMOST_EMPTY(c_ae), .COUNT(c_cnt),
        .OVERFLOW(c_ovf), .UNDERFLOW(c_udf));

    typedef struct {
        logic       rst;
        logic       w;
        logic [7:0] d;
        logic       r;
        int         cnt;
        logic       ovf;
        logic       udf;
        logic       rv;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb[$];
    int         n_vec = 0;
    int         n_err = 0;

    function automatic vec_t mk(input logic rst, input logic w, input logic [7:0] d, input logic r,
                                input int cnt, input logic ovf, input logic udf, input logic rv);
        vec_t v;
        v.rst = rst; v.w = w; v.d = d; v.r = r;
        v.cnt = cnt; v.ovf = ovf; v.udf = udf; v.rv = rv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_pop(input string nm, input logic [7:0] act);
        if (sb.size() == 0) chk({nm, "_sb_empty"}, 32'd1, 32'd0);
        else chk(nm, act, sb.pop_front());
    endtask

    initial begin
        int prev_cnt;
        vec_t v;

        a_rst = 1'b1; a_w = 1'b0; a_r = 1'b0; a_wd = '0;
        b_rst = 1'b1; b_w = 1'b0; b_r = 1'b0; b_wd = '0;
        c_rst = 1'b1; c_w = 1'b0; c_r = 1'b0; c_wd = '0;
        tick();
        b_rst = 1'b0;
        c_rst = 1'b0;

        // ---- instance A vector table ----
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 8; i++) tbl.push_back(mk(0, 1, 8'(i), 0, i, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h99, 0, 8, 1, 0, 0));           // write while full
        tbl.push_back(mk(0, 0, 8'h00, 0, 8, 0, 0, 0));           // pulse lasts one cycle
        for (int i = 1; i <= 8; i++) tbl.push_back(mk(0, 0, 8'h00, 1, 8 - i, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0));           // read while empty
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h11, 1, 1, 0, 1, 0));           // W&R at empty
        for (int i = 2; i <= 8; i++) tbl.push_back(mk(0, 1, 8'(8'h10 + i), 0, i, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h77, 1, 7, 1, 0, 1));           // W&R at full
        tbl.push_back(mk(0, 1, 8'h20, 1, 7, 0, 0, 1));           // W&R mid-level
        tbl.push_back(mk(1, 1, 8'h55, 0, 0, 0, 0, 0));           // reset beats write
        tbl.push_back(mk(0, 1, 8'h33, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));

        prev_cnt = 0;
        foreach (tbl[i]) begin
            v = tbl[i];
            a_rst = v.rst; a_w = v.w; a_wd = v.d; a_r = v.r;
            if (v.rst) sb.delete();
            else if (v.w && prev_cnt < 8) sb.push_back(v.d);
            tick();
            chk($sformatf("a%0d_count", i), 32'(a_cnt), 32'(v.cnt));
            chk($sformatf("a%0d_full", i), 32'(a_full), 32'(v.cnt == 8));
            chk($sformatf("a%0d_empty", i), 32'(a_empty), 32'(v.cnt == 0));
            chk($sformatf("a%0d_afull", i), 32'(a_af), 32'(v.cnt >= 6));
            chk($sformatf("a%0d_aempty", i), 32'(a_ae), 32'(v.cnt <= 1));
            chk($sformatf("a%0d_overflow", i), 32'(a_ovf), 32'(v.ovf));
            chk($sformatf("a%0d_underflow", i), 32'(a_udf), 32'(v.udf));
            chk($sformatf("a%0d_rd_valid", i), 32'(a_rv), 32'(v.rv));
            if (i == 0) chk("a0_rd_data_reset", 32'(a_rd), 32'h0);
            if (a_rv === 1'b1) chk_pop($sformatf("a%0d_rd_data", i), a_rd);
            prev_cnt = v.cnt;
        end
        a_rst = 1'b0; a_w = 1'b0; a_r = 1'b0;

        // ---- instance B: DEPTH 5 wrap with paired write/read ----
        sb.delete();
        b_w = 1'b1;
        b_wd = 8'hB0; sb.push_back(b_wd); tick();
        b_wd = 8'hB1; sb.push_back(b_wd); tick();
        chk("b_prefill_count", 32'(b_cnt), 32'd2);
        b_r = 1'b1;
        for (int i = 0; i < 13; i++) begin
            b_wd = 8'(8'h40 + i);
            sb.push_back(b_wd);
            tick();
            chk($sformatf("b%0d_count", i), 32'(b_cnt), 32'd2);
            chk($sformatf("b%0d_rd_valid", i), 32'(b_rv), 32'd1);
            chk_pop($sformatf("b%0d_rd_data", i), b_rd);
        end
        b_w = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("b_drain%0d_rd_valid", i), 32'(b_rv), 32'd1);
            chk_pop($sformatf("b_drain%0d_rd_data", i), b_rd);
        end
        b_r = 1'b0;
        tick();
        chk("b_end_empty", 32'(b_empty), 32'd1);
        chk("b_end_rd_valid", 32'(b_rv), 32'd0);
        chk("b_end_count", 32'(b_cnt), 32'd0);

        // ---- instance C: fall-through read and mid-fill reset ----
        chk("c_reset_rd_valid", 32'(c_rv), 32'd0);
        c_w = 1'b1; c_wd = 8'hA5; tick();
        c_w = 1'b0;
        chk("c_first_rd_valid", 32'(c_rv), 32'd1);
        chk("c_first_rd_data", 32'(c_rd), 32'hA5);
        chk("c_first_count", 32'(c_cnt), 32'd1);
        c_w = 1'b1; c_wd = 8'hB6; tick();
        c_wd = 8'hC7; tick();
        c_w = 1'b0;
        chk("c_head_held", 32'(c_rd), 32'hA5);
        chk("c_fill3_count", 32'(c_cnt), 32'd3);
        c_r = 1'b1; tick();
        c_r = 1'b0;
        chk("c_pop_rd_data", 32'(c_rd), 32'hB6);
        chk("c_pop_count", 32'(c_cnt), 32'd2);
        c_w = 1'b1; c_wd = 8'hD8; tick();
        chk("c_refill_count", 32'(c_cnt), 32'd3);
        c_rst = 1'b1; tick();
        c_rst = 1'b0; c_w = 1'b0;
        chk("c_rst_count", 32'(c_cnt), 32'd0);
        chk("c_rst_empty", 32'(c_empty), 32'd1);
        chk("c_rst_rd_valid", 32'(c_rv), 32'd0);
        chk("c_rst_aempty", 32'(c_ae), 32'd1);
        tick();
        chk("c_after_rst_count", 32'(c_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
